// File: rtl/sample_mul_pkg.sv
// Shared defaults for the sample multiplier arbiter: operand/result widths,
// requester count and the saturation bound helpers used by sample_mul_core.
package sample_mul_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int A_WIDTH_DEF = 8;
  localparam int B_WIDTH_DEF = 14;
  localparam int P_WIDTH_DEF = 14;

  // Largest and smallest signed values representable in pw bits.
  function automatic longint sat_hi(input int pw);
    return (longint'(1) <<< (pw - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_lo(input int pw);
    return -(longint'(1) <<< (pw - 1));
  endfunction

  localparam longint SAT_MAX_DEF = sat_hi(P_WIDTH_DEF);
  localparam longint SAT_MIN_DEF = sat_lo(P_WIDTH_DEF);

endpackage

// File: rtl/sample_mul_core.sv
// Combinational unsigned-by-signed multiply reduced to P_WIDTH bits.
// SAMPLE_MUL_ARB_SAT_EN selects saturation; otherwise the product wraps.
module sample_mul_core
  import sample_mul_pkg::*;
#(
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int B_WIDTH = B_WIDTH_DEF,
  parameter int P_WIDTH = P_WIDTH_DEF
) (
  input  logic        [A_WIDTH-1:0] a,
  input  logic signed [B_WIDTH-1:0] b,
  output logic signed [P_WIDTH-1:0] p
);

  localparam int FW = A_WIDTH + B_WIDTH + 1;

  // A is zero-extended and B sign-extended so one signed multiply covers both.
  logic signed [FW-1:0] a_ext;
  logic signed [FW-1:0] b_ext;

  assign a_ext = {{(B_WIDTH + 1){1'b0}}, a};
  assign b_ext = {{(A_WIDTH + 1){b[B_WIDTH-1]}}, b};

`ifdef SAMPLE_MUL_ARB_SAT_EN
  localparam logic signed [FW-1:0] HI = FW'(sat_hi(P_WIDTH));
  localparam logic signed [FW-1:0] LO = FW'(sat_lo(P_WIDTH));

  logic signed [FW-1:0] full;

  assign full = a_ext * b_ext;

  always_comb begin
    if (full > HI) begin
      p = HI[P_WIDTH-1:0];
    end else if (full < LO) begin
      p = LO[P_WIDTH-1:0];
    end else begin
      p = full[P_WIDTH-1:0];
    end
  end
`else
  assign p = P_WIDTH'(a_ext * b_ext);
`endif

endmodule

// File: rtl/sample_mul_arbiter.sv
// Round-robin arbiter feeding a two-stage multiplier pipeline (S1 operands,
// S2 product). SAMPLE_MUL_ARB_SAT_EN switches the core from wrap to saturate.
module sample_mul_arbiter
  import sample_mul_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int B_WIDTH = B_WIDTH_DEF,
  parameter int P_WIDTH = P_WIDTH_DEF
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic signed [P_WIDTH-1:0]    rsp_p,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic                         busy
);

  localparam int IW = $clog2(NUM_REQ);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a presented response holds steady until rsp_ready is seen.
  logic                      s1_valid;
  logic        [A_WIDTH-1:0] s1_a;
  logic signed [B_WIDTH-1:0] s1_b;
  logic        [IW-1:0]      s1_id;
  logic        [IW-1:0]      ptr;

  logic                      s2_adv;
  logic                      s1_open;
  logic [NUM_REQ-1:0]        grant;
  logic        [IW-1:0]      gid;
  logic        [A_WIDTH-1:0] sel_a;
  logic signed [B_WIDTH-1:0] sel_b;
  logic                      take;
  logic signed [P_WIDTH-1:0] core_p;

  assign s2_adv  = !rsp_valid || rsp_ready;
  assign s1_open = ap_rst_n && (!s1_valid || s2_adv);

  // Rotating priority search starting at ptr; depends only on req_valid.
  always_comb begin
    int idx;
    logic found;
    grant = '0;
    gid   = '0;
    sel_a = '0;
    sel_b = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gid        = IW'(idx);
        sel_a      = req_a[idx*A_WIDTH +: A_WIDTH];
        sel_b      = req_b[idx*B_WIDTH +: B_WIDTH];
      end
    end
  end

  assign req_ready = s1_open ? grant : '0;
  assign take      = |req_ready;
  assign busy      = s1_valid || rsp_valid;

  sample_mul_core #(
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH),
    .P_WIDTH (P_WIDTH)
  ) u_core (
    .a (s1_a),
    .b (s1_b),
    .p (core_p)
  );

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_id     <= '0;
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_p     <= '0;
      rsp_id    <= '0;
    end else begin
      if (s2_adv) begin
        rsp_valid <= s1_valid;
        if (s1_valid) begin
          rsp_p  <= core_p;
          rsp_id <= s1_id;
        end
      end
      if (take) begin
        s1_valid <= 1'b1;
        s1_a     <= sel_a;
        s1_b     <= sel_b;
        s1_id    <= gid;
        ptr      <= (gid == IW'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sample_mul_arbiter.sv
// Scoreboard bench for sample_mul_arbiter: directed corner cases plus
// randomized traffic against a queue-based reference model.
module tb_sample_mul_arbiter;

  localparam int NUM_REQ = 4;
  localparam int A_W     = 8;
  localparam int B_W     = 14;
  localparam int P_W     = 14;
  localparam int IW      = 2;
  localparam int W       = IW + P_W;

  logic                   ap_clk;
  logic                   ap_rst_n;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic signed [P_W-1:0]  rsp_p;
  logic [IW-1:0]          rsp_id;
  logic                   busy;

  sample_mul_arbiter #(
    .NUM_REQ (NUM_REQ),
    .A_WIDTH (A_W),
    .B_WIDTH (B_W),
    .P_WIDTH (P_W)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;
  int n_infl = 0;
  int ptr_m  = 0;
  logic held = 1'b0;
  logic post_rst = 1'b0;
  logic signed [P_W-1:0] held_p;
  logic [IW-1:0] held_id;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Product reduced to P_W bits using plain integer arithmetic.
  function automatic int ref_p(input int a, input int b);
    longint full;
    longint w;
    full = longint'(a) * longint'(b);
`ifdef SAMPLE_MUL_ARB_SAT_EN
    if (full > (longint'(1) <<< (P_W - 1)) - 1) w = (longint'(1) <<< (P_W - 1)) - 1;
    else if (full < -(longint'(1) <<< (P_W - 1))) w = -(longint'(1) <<< (P_W - 1));
    else w = full;
`else
    w = full & ((longint'(1) <<< P_W) - 1);
    if (w >= (longint'(1) <<< (P_W - 1))) w = w - (longint'(1) <<< P_W);
`endif
    return int'(w);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge ap_clk) begin
    logic [NUM_REQ-1:0] exp_ready;
    int g;
    int a_v;
    int b_v;
    logic [W-1:0] item;
    logic signed [P_W-1:0] ep;
    if (!ap_rst_n) begin
      exp_q.delete();
      n_infl   = 0;
      ptr_m    = 0;
      held     = 1'b0;
      post_rst = 1'b1;
    end else begin
      if (post_rst) begin
        check("post_reset_rsp_valid", rsp_valid, 0);
        check("post_reset_busy", busy, 0);
        post_rst = 1'b0;
      end
      exp_ready = '0;
      g = 0;
      if (n_infl < 2 || rsp_ready) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          int idx;
          idx = (ptr_m + k) % NUM_REQ;
          if (exp_ready == '0 && req_valid[idx]) begin
            exp_ready[idx] = 1'b1;
            g = idx;
          end
        end
      end
      check("req_ready", req_ready, exp_ready);
      check("busy", busy, (n_infl > 0) ? 1 : 0);
      if (held) begin
        check("stall_rsp_valid", rsp_valid, 1);
        check("stall_rsp_p", rsp_p, held_p);
        check("stall_rsp_id", rsp_id, held_id);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp_queue_size", 0, 1);
        end else begin
          item = exp_q.pop_front();
          ep = item[P_W-1:0];
          check("rsp_p", rsp_p, ep);
          check("rsp_id", rsp_id, item[W-1:P_W]);
        end
        n_infl--;
      end
      if (exp_ready != '0) begin
        a_v = int'(req_a[g*A_W +: A_W]);
        b_v = int'($signed(req_b[g*B_W +: B_W]));
        exp_q.push_back({IW'(g), P_W'(ref_p(a_v, b_v))});
        n_infl++;
        ptr_m = (g + 1) % NUM_REQ;
      end
      held    = rsp_valid && !rsp_ready;
      held_p  = rsp_p;
      held_id = rsp_id;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_op(input int id, input int a, input int b);
    logic [B_W-1:0] bb;
    bb = B_W'(b);
    req_a[id*A_W +: A_W] = A_W'(a);
    req_b[id*B_W +: B_W] = bb;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      set_op(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 16383)) - 8192);
    end
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      tick();
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic pulse_reset();
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
  endtask

  // Single isolated operation with a fixed expected result and latency.
  task automatic single_op(input int id, input int a, input int b, input int exp_p);
    rsp_ready = 1'b1;
    req_valid = '0;
    req_valid[id] = 1'b1;
    set_op(id, a, b);
    tick();
    req_valid = '0;
    @(negedge ap_clk);
    check("latency_early_rsp_valid", rsp_valid, 0);
    @(negedge ap_clk);
    check("latency_rsp_valid", rsp_valid, 1);
    check("single_rsp_p", rsp_p, exp_p);
    check("single_rsp_id", rsp_id, id);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int accepts;
    ap_rst_n  = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    @(negedge ap_clk);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_rsp_p", rsp_p, 0);
    check("reset_rsp_id", rsp_id, 0);
    req_valid = '1;
    #1;
    check("reset_req_ready", req_ready, 0);
    req_valid = '0;
    tick();
    ap_rst_n = 1'b1;

    single_op(2, 3, -5, -15);
`ifdef SAMPLE_MUL_ARB_SAT_EN
    single_op(0, 255, 8191, 8191);
`else
    single_op(0, 255, 8191, 7937);
`endif
    single_op(3, 255, -8192, -8192);
    drain();

    // All requesters valid straight out of reset: strict rotation.
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n  = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    rand_ops();
    for (int k = 0; k < 6; k++) begin
      @(negedge ap_clk);
      check("rr_order", req_ready, 1 << (k % NUM_REQ));
      tick();
      rand_ops();
    end
    drain();

    // Downstream stalled while requester 0 streams.
    accepts = 0;
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      @(negedge ap_clk);
      if (req_ready[0]) accepts++;
      tick();
      set_op(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 16383)) - 8192);
    end
    check("stall_accepts", accepts, 2);
    drain();

    // Reset with both stages full, then rotation restarts at requester 0.
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    rand_ops();
    tick();
    tick();
    tick();
    req_valid = '0;
    pulse_reset();
    req_valid = '1;
    rsp_ready = 1'b1;
    @(negedge ap_clk);
    check("rr_after_reset", req_ready, 1);
    tick();
    drain();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset();
      end
      req_valid = NUM_REQ'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 9) < 7);
      rand_ops();
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_mul_arbiter.md
SAMPLE_MUL_ARBITER -- requirements
Module: sample_mul_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one multiplier (2..8).
REQ-002 SHALL have parameter A_WIDTH, default 8, unsigned operand width.
REQ-003 SHALL have parameter B_WIDTH, default 14, signed operand width.
REQ-004 SHALL have parameter P_WIDTH, default 14, signed result width.
REQ-005 SHALL have port ap_clk, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port ap_rst_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port req_valid, input, NUM_REQ, per-requester operand valid.
REQ-008 SHALL have port req_ready, output, NUM_REQ, per-requester accept; at most one bit high per cycle.
REQ-009 SHALL have port req_a, input, NUM_REQ*A_WIDTH, unsigned operand A; requester i in slice i.
REQ-010 SHALL have port req_b, input, NUM_REQ*B_WIDTH, signed operand B; requester i in slice i.
REQ-011 SHALL have port rsp_valid, output, 1, result valid.
REQ-012 SHALL have port rsp_ready, input, 1, downstream accept.
REQ-013 SHALL have port rsp_p, output, P_WIDTH, signed product.
REQ-014 SHALL have port rsp_id, output, clog2(NUM_REQ), index of the originating requester.
REQ-015 SHALL have port busy, output, 1, high when either pipeline stage holds data.

Function
REQ-016 SHALL transfer a request on cycles where req_valid[i] and req_ready[i] are both high; response transfers on rsp_valid and rsp_ready.
REQ-017 SHALL use a two-stage pipeline: S1 operand/ID register, S2 product register driving rsp_*.
REQ-018 SHALL present a result on rsp_valid two cycles after acceptance when unstalled; throughput one result per cycle.
REQ-019 SHALL advance S2 when S2 is empty or rsp_ready is high; SHALL advance S1 into S2 only when S2 advances.
REQ-020 SHALL assert req_ready for exactly one valid requester when S1 is empty or advancing, and for none otherwise.
REQ-021 SHALL grant round-robin: a pointer starts at 0; after a grant to i, priority order is i+1, i+2, ... mod NUM_REQ; the pointer is unchanged on no-grant cycles.
REQ-022 SHALL compute the full product as {0,A} times signed B (A_WIDTH+B_WIDTH bits), then reduce to P_WIDTH per REQ-029.
REQ-023 SHALL hold rsp_p, rsp_id and rsp_valid stable while rsp_valid is high and rsp_ready is low.
REQ-024 SHALL ignore requester inputs whose req_valid is low; req_ready SHALL not depend combinationally on the same requester's operand data.
REQ-025 SHALL not lose, duplicate or reorder accepted operations; results leave in acceptance order.

Reset
REQ-026 SHALL, with ap_rst_n low at a rising edge, clear both stage valids, the RR pointer to 0, rsp_valid, req_ready, busy to 0, and rsp_p and rsp_id to 0.
REQ-027 SHALL discard in-flight operations on reset mid-operation; no result for them appears afterwards.
REQ-028 SHALL accept a request on the first cycle after ap_rst_n returns high.

Configuration
REQ-029 SHALL, with SAMPLE_MUL_ARB_SAT_EN defined, saturate the full product to [-2^(P_WIDTH-1), 2^(P_WIDTH-1)-1]; without it, SHALL truncate to the low P_WIDTH bits (two's-complement wrap).

Structure
REQ-030 SHALL place A/B/P default widths, NUM_REQ default and the saturation bounds in a shared package sample_mul_pkg.
REQ-031 SHALL instantiate one sub-module sample_mul_core (combinational unsigned-by-signed multiply plus REQ-029 reduction) between S1 and S2.

Verification
REQ-032 Single request i=2, a=3, b=-5, rsp_ready=1 -> rsp_valid two cycles later, rsp_p=-15, rsp_id=2.
REQ-033 All four req_valid high continuously from reset -> grants in order 0,1,2,3,0; one result per cycle.
REQ-034 a=255, b=8191 -> rsp_p=7937 without SAMPLE_MUL_ARB_SAT_EN, 8191 with it; a=255, b=-8192 -> -8192 both builds.
REQ-035 rsp_ready low 4 cycles with req 0 streaming -> exactly 2 accepts then req_ready low; rsp_* stable; no loss after release.
REQ-036 ap_rst_n low 1 cycle with both stages full -> rsp_valid=0, busy=0 next cycle; RR restarts at requester 0.
